lgn_argmax_seq: RTL and testbench
=================================

Name: lgn_argmax_seq

Overview:
- Sequential, parametrised successor to the combinational per-category popcount and arg-max stage at the output of the logic-gate network.
- Captures one flattened category bit-vector and popcounts it CHUNK bits per cycle with one shared counter.
- Tracks the running best and second-best category, then presents the winning index, its score and the winning margin over a valid/ready handshake.
- Sits between `net` and the display/output mux in the top level; trades latency for area.

Parameters:
- CATEGORIES, 10, number of output classes (≥2).
- BITS_PER_CATEGORY, 511, output bits voting for each class.
- CHUNK, 64, bits popcounted per cycle (1..BITS_PER_CATEGORY).
- Derived, not overridable:
  - SUM_W = $clog2(BITS_PER_CATEGORY+1), so an all-ones category does not overflow.
  - IDX_W = max(1,$clog2(CATEGORIES)).
  - CPC = ceil(BITS_PER_CATEGORY/CHUNK), chunks per category.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  category vector offered.
- in_ready  out  1  block can accept a vector.
- in_bits  in  CATEGORIES*BITS_PER_CATEGORY  category i occupies [i*BITS_PER_CATEGORY +: BITS_PER_CATEGORY].
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_index  out  IDX_W  winning category.
- out_value  out  SUM_W  popcount of the winner.
- out_margin  out  SUM_W  winner score minus second-best score.
- busy  out  1  high while in BUSY state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values (also applied on assertion mid-operation, discarding any in-flight vector):
  - State IDLE, in_ready=1.
  - out_valid=0, out_index=0, out_value=0, out_margin=0, busy=0.
  - Category, chunk and accumulator counters = 0.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a clock edge: register in_bits into an internal capture register; clear acc, best, second, best_idx, cat and chunk counters; go to BUSY.
- State BUSY:
  - in_ready=0, busy=1.
  - Each cycle, popcount chunk `chunk` of category `cat` from the capture register.
  - The final chunk of a category has bits beyond BITS_PER_CATEGORY masked to 0; no bits of the next category leak in.
  - Non-final chunk: acc += pop; chunk++.
  - Final chunk: s = acc+pop; then
    - if cat==0 or s>best: second<=best, best<=s, best_idx<=cat;
    - else if s>second: second<=s;
    - acc<=0, chunk<=0, cat++.
  - After the final chunk of category CATEGORIES-1: go to DONE.
- State DONE:
  - out_valid=1, busy=0, in_ready=0.
  - out_index=best_idx, out_value=best, out_margin=best-second.
  - Outputs are registered and held stable until out_ready.
  - On out_valid&out_ready: out_valid<=0 and go to IDLE. The result registers keep their last values.
  - A new vector is accepted no earlier than the cycle after the handshake.
- Ties:
  - A strictly greater score is required to displace the best, so the lowest index wins.
  - A tie with best gives margin 0.
- Latency: accept edge to out_valid high is exactly CATEGORIES*CPC cycles (80 at defaults). Throughput is one vector per CATEGORIES*CPC+2 cycles with out_ready held high.
- Changes to in_bits after the accept edge have no effect.
- in_valid in BUSY or DONE is ignored; no queueing.
- Arithmetic: acc, best and second are SUM_W wide; a sum never exceeds BITS_PER_CATEGORY, so no overflow is possible.

Decomposition:
- Package lgn_pkg:
  - default localparams CATEGORIES / BITS_PER_CATEGORY;
  - a function for ceil-div;
  - the state enum type (IDLE, BUSY, DONE).
- One sub-module, popcount_chunk #(CHUNK):
  - combinational popcount of CHUNK bits with a valid-bit mask input;
  - output width $clog2(CHUNK+1).
- Everything else stays in lgn_argmax_seq.

Test Plan:
1. Reset mid-BUSY: accept a vector, assert rst at cycle 20 → out_valid=0, in_ready=1 immediately (asynchronous); the next vector processes normally.
2. Default params, category 3 = all 511 ones, others = 100 ones each → out_valid exactly 80 cycles after the accept edge; out_index=3, out_value=511, out_margin=411.
3. Tie: categories 2 and 7 both 300 ones, the rest 0 → out_index=2, out_value=300, out_margin=0.
4. Masking: all categories zero except the bits of category 5, with CHUNK=64 → category 4's final 63-bit chunk is unaffected; out_index=5, out_value=511, out_margin=511.
5. Backpressure: hold out_ready=0 for 50 cycles after out_valid → outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 for one cycle → out_valid drops and in_ready=1 on the next cycle.
6. Param sweep CATEGORIES=4, BITS_PER_CATEGORY=16, CHUNK=16, random vectors vs reference model → index/value/margin match; latency is 4 cycles.

Source files
------------

// File: rtl/lgn_pkg.sv
// Shared defaults, helpers and state type for the sequential
// category popcount / arg-max stage.
package lgn_pkg;

  localparam int CATEGORIES_DEF        = 10;
  localparam int BITS_PER_CATEGORY_DEF = 511;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/popcount_chunk.sv
// Combinational popcount of one CHUNK-bit slice; bits outside
// the mask are ignored.
module popcount_chunk
  import lgn_pkg::*;
#(
  parameter  int CHUNK = 64,
  localparam int CW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  input  logic [CHUNK-1:0] mask,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + CW'(bits[i] & mask[i]);
    end
  end

endmodule

// File: rtl/lgn_argmax_seq.sv
// Sequential per-category popcount and arg-max: one shared CHUNK-bit
// counter walks the captured vector, tracking best and second-best.
module lgn_argmax_seq
  import lgn_pkg::*;
#(
  parameter  int CATEGORIES        = CATEGORIES_DEF,
  parameter  int BITS_PER_CATEGORY = BITS_PER_CATEGORY_DEF,
  parameter  int CHUNK             = 64,
  localparam int SUM_W = $clog2(BITS_PER_CATEGORY + 1),
  localparam int IDX_W = (CATEGORIES > 1) ? $clog2(CATEGORIES) : 1,
  localparam int VEC_W = CATEGORIES * BITS_PER_CATEGORY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [SUM_W-1:0] out_value,
  output logic [SUM_W-1:0] out_margin,
  output logic             busy
);

  localparam int CPC    = ceil_div(BITS_PER_CATEGORY, CHUNK);
  localparam int PAD_W  = CPC * CHUNK;
  localparam int CH_W   = (CPC > 1) ? $clog2(CPC) : 1;
  localparam int PC_W   = $clog2(CHUNK + 1);
  localparam int LAST_N = BITS_PER_CATEGORY - (CPC - 1) * CHUNK;

  localparam logic [CHUNK-1:0] LAST_MASK =
    {CHUNK{1'b1}} >> (CHUNK - LAST_N);
  localparam logic [IDX_W-1:0] LAST_CAT = IDX_W'(CATEGORIES - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CPC - 1);

  state_t state, state_nx;

  logic [VEC_W-1:0] cap;
  logic [CPC-1:0][CHUNK-1:0] pad [CATEGORIES];

  logic [IDX_W-1:0] cat, best_idx, best_idx_nx;
  logic [CH_W-1:0]  chunk;
  logic [SUM_W-1:0] acc, best, second;
  logic [SUM_W-1:0] sum, best_nx, second_nx;
  logic [CHUNK-1:0] chunk_bits, mask;
  logic [PC_W-1:0]  pop;
  logic             last_chunk, last_cat, accept;

  // Each category is zero-padded to whole chunks, so the final
  // chunk can never pick up bits of its neighbour.
  for (genvar c = 0; c < CATEGORIES; c++) begin : g_pad
    assign pad[c] = PAD_W'(cap[c*BITS_PER_CATEGORY +: BITS_PER_CATEGORY]);
  end

  assign chunk_bits = pad[cat][chunk];
  assign last_chunk = (chunk == LAST_CH);
  assign last_cat   = (cat == LAST_CAT);
  assign mask       = last_chunk ? LAST_MASK : '1;

  popcount_chunk #(.CHUNK(CHUNK)) u_pop (
    .bits  (chunk_bits),
    .mask  (mask),
    .count (pop)
  );

  assign sum      = acc + SUM_W'(pop);
  assign in_ready = (state == IDLE);
  assign busy     = (state == BUSY);
  assign accept   = in_valid & in_ready;

  always_comb begin
    best_nx     = best;
    second_nx   = second;
    best_idx_nx = best_idx;
    if (cat == '0 || sum > best) begin
      second_nx   = best;
      best_nx     = sum;
      best_idx_nx = cat;
    end else if (sum > second) begin
      second_nx = sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = BUSY;
      BUSY:    if (last_chunk && last_cat) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) cap <= in_bits;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cat        <= '0;
      chunk      <= '0;
      acc        <= '0;
      best       <= '0;
      second     <= '0;
      best_idx   <= '0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_value  <= '0;
      out_margin <= '0;
    end else if (accept) begin
      cat      <= '0;
      chunk    <= '0;
      acc      <= '0;
      best     <= '0;
      second   <= '0;
      best_idx <= '0;
    end else if (busy) begin
      if (last_chunk) begin
        acc      <= '0;
        chunk    <= '0;
        best     <= best_nx;
        second   <= second_nx;
        best_idx <= best_idx_nx;
        if (last_cat) begin
          cat        <= '0;
          out_valid  <= 1'b1;
          out_index  <= best_idx_nx;
          out_value  <= best_nx;
          out_margin <= best_nx - second_nx;
        end else begin
          cat <= cat + 1'b1;
        end
      end else begin
        acc   <= sum;
        chunk <= chunk + 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lgn_argmax_seq.sv
// Scoreboard bench: drivers push model results, monitors pop and
// compare when out_valid rises on each DUT instance.
module tb_lgn_argmax_seq;

  localparam int BC = 10, BB = 511, BK = 64;
  localparam int SC = 4,  SB = 16,  SK = 16;
  localparam int BW = BC * BB;
  localparam int SW = SC * SB;

  typedef struct {
    int idx;
    int val;
    int mar;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  logic          b_iv = 1'b0, b_or = 1'b1;
  logic          b_ir, b_ov, b_busy;
  logic [BW-1:0] b_bits = '0;
  logic [3:0]    b_idx;
  logic [8:0]    b_val, b_mar;

  logic          s_iv = 1'b0, s_or = 1'b1;
  logic          s_ir, s_ov, s_busy;
  logic [SW-1:0] s_bits = '0;
  logic [1:0]    s_idx;
  logic [4:0]    s_val, s_mar;

  exp_t qb[$];
  exp_t qs[$];
  logic bp = 1'b0, sp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lgn_argmax_seq #(
    .CATEGORIES(BC), .BITS_PER_CATEGORY(BB), .CHUNK(BK)
  ) u_big (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_bits(b_bits),
    .out_valid(b_ov), .out_ready(b_or),
    .out_index(b_idx), .out_value(b_val), .out_margin(b_mar),
    .busy(b_busy)
  );

  lgn_argmax_seq #(
    .CATEGORIES(SC), .BITS_PER_CATEGORY(SB), .CHUNK(SK)
  ) u_small (
    .clk(clk), .rst(rst),
    .in_valid(s_iv), .in_ready(s_ir), .in_bits(s_bits),
    .out_valid(s_ov), .out_ready(s_or),
    .out_index(s_idx), .out_value(s_val), .out_margin(s_mar),
    .busy(s_busy)
  );

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic to_fail(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Reference: score every category, argmax by first occurrence,
  // margin against the second entry of the sorted score list.
  function automatic exp_t model(input logic [BW-1:0] v,
                                 input int cats, input int bpc);
    exp_t r;
    int sc[$];
    int srt[$];
    int bv = -1;
    r.idx = 0;
    for (int c = 0; c < cats; c++) begin
      int s = 0;
      for (int b = 0; b < bpc; b++) s += int'(v[c*bpc + b]);
      sc.push_back(s);
      if (s > bv) begin
        bv = s;
        r.idx = c;
      end
    end
    srt = sc;
    srt.rsort();
    r.val = srt[0];
    r.mar = srt[0] - srt[1];
    r.acc = 0;
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd_big();
    logic [BW-1:0] v;
    for (int c = 0; c < BC; c++) begin
      int p = $urandom_range(0, 100);
      for (int b = 0; b < BB; b++)
        v[c*BB + b] = ($urandom_range(0, 99) < p);
    end
    return v;
  endfunction

  task automatic drive_big(input logic [BW-1:0] v);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!b_ir && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      to_fail("big_accept");
      return;
    end
    b_iv = 1'b1;
    b_bits = v;
    e = model(v, BC, BB);
    e.acc = cyc + 1;
    qb.push_back(e);
    @(negedge clk);
    b_iv = 1'b0;
    b_bits = rnd_big();
  endtask

  task automatic drive_small(input logic [SW-1:0] v);
    exp_t e;
    logic [BW-1:0] w;
    int t = 0;
    @(negedge clk);
    while (!s_ir && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      to_fail("small_accept");
      return;
    end
    s_iv = 1'b1;
    s_bits = v;
    w = '0;
    w[SW-1:0] = v;
    e = model(w, SC, SB);
    e.acc = cyc + 1;
    qs.push_back(e);
    @(negedge clk);
    s_iv = 1'b0;
    s_bits = {$urandom(), $urandom()};
  endtask

  task automatic drain();
    int t = 0;
    while ((qb.size() != 0 || qs.size() != 0 || b_ov || s_ov)
           && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) to_fail("drain");
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) bp = 1'b0;
    else begin
      if (b_ov && !bp) begin
        if (qb.size() == 0) to_fail("big_unexpected_result");
        else begin
          e = qb.pop_front();
          check("big_index", int'(b_idx), e.idx);
          check("big_value", int'(b_val), e.val);
          check("big_margin", int'(b_mar), e.mar);
          check("big_latency", cyc - e.acc, 80);
        end
      end
      bp = b_ov;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) sp = 1'b0;
    else begin
      if (s_ov && !sp) begin
        if (qs.size() == 0) to_fail("small_unexpected_result");
        else begin
          e = qs.pop_front();
          check("small_index", int'(s_idx), e.idx);
          check("small_value", int'(s_val), e.val);
          check("small_margin", int'(s_mar), e.mar);
          check("small_latency", cyc - e.acc, 4);
        end
      end
      sp = s_ov;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] v;
    logic [SW-1:0] w;
    int t;
    logic [3:0] hi;
    logic [8:0] hv, hm;

    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(b_ov), 0);
    check("rst_in_ready", int'(b_ir), 1);
    check("rst_busy", int'(b_busy), 0);
    check("rst_index", int'(b_idx), 0);
    check("rst_value", int'(b_val), 0);
    check("rst_margin", int'(b_mar), 0);
    check("rst_small_ready", int'(s_ir), 1);
    rst = 1'b0;

    // Reset mid-BUSY discards the in-flight vector.
    drive_big(rnd_big());
    repeat (18) @(negedge clk);
    check("pre_rst_busy", int'(b_busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", int'(b_ov), 0);
    check("mid_rst_in_ready", int'(b_ir), 1);
    check("mid_rst_busy", int'(b_busy), 0);
    qb.delete();
    @(negedge clk);
    rst = 1'b0;

    v = '0;
    for (int c = 0; c < BC; c++)
      for (int b = 0; b < (c == 3 ? BB : 100); b++) v[c*BB + b] = 1'b1;
    drive_big(v);
    drain();

    v = '0;
    for (int b = 0; b < 300; b++) begin
      v[2*BB + b] = 1'b1;
      v[7*BB + BB - 1 - b] = 1'b1;
    end
    drive_big(v);
    drain();

    v = '0;
    for (int b = 0; b < BB; b++) v[5*BB + b] = 1'b1;
    drive_big(v);
    drain();

    for (int n = 0; n < 8; n++) drive_big(rnd_big());
    drain();

    // Backpressure: result held, new offer ignored.
    b_or = 1'b0;
    drive_big(rnd_big());
    t = 0;
    while (!b_ov && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) to_fail("bp_out_valid");
    hi = b_idx;
    hv = b_val;
    hm = b_mar;
    b_iv = 1'b1;
    b_bits = rnd_big();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("bp_hold_valid", int'(b_ov), 1);
      check("bp_in_ready", int'(b_ir), 0);
      check("bp_hold_index", int'(b_idx), int'(hi));
      check("bp_hold_value", int'(b_val), int'(hv));
      check("bp_hold_margin", int'(b_mar), int'(hm));
    end
    b_iv = 1'b0;
    b_or = 1'b1;
    @(negedge clk);
    check("bp_release_valid", int'(b_ov), 0);
    check("bp_release_ready", int'(b_ir), 1);
    drain();

    for (int n = 0; n < 40; n++) begin
      w = {$urandom(), $urandom()};
      if (n % 4 == 1) w[2*SB +: SB] = w[0 +: SB];
      if (n % 7 == 3) w = '0;
      drive_small(w);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
